// File: rtl/leaf_noc_pkg.sv
// Shared definitions for the leaf router control plane: port indices,
// crossbar direction codes, destination address fields and FSM states.
package leaf_noc_pkg;

    localparam int         NUM_REQ  = 5;
    localparam logic [2:0] PORT_GPU = 3'd0;
    localparam logic [2:0] PORT_SP1 = 3'd1;
    localparam logic [2:0] PORT_SP2 = 3'd2;
    localparam logic [2:0] PORT_SP3 = 3'd3;
    localparam logic [2:0] PORT_SP4 = 3'd4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_UP   = 2'b10,
        DIR_DROP = 2'b11
    } dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    function automatic logic [3:0] addr_group(input logic [5:0] addr);
        return addr[5:2];
    endfunction

    function automatic logic [1:0] addr_router(input logic [5:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/leaf_xbar_scheduler_if.sv
// Requester/output-port handshake and grant status bundle of the leaf crossbar scheduler.
interface leaf_xbar_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             arb_enable;
    logic [4:0]       req_valid;
    logic [4:0]       req_last;
    logic [29:0]      req_dest_addr;
    logic [4:0]       out_ready;
    logic [4:0]       req_pop;
    logic             grant_valid;
    logic [2:0]       current_grant;
    logic [2:0]       route_sel;
    logic [1:0]       direction;
    logic             busy;
    logic [CNT_W-1:0] beat_count;
    logic             pkt_done;
    logic             timeout_err;
    logic             drop_err;

    modport master (
        output arb_enable, req_valid, req_last, req_dest_addr, out_ready,
        input  req_pop, grant_valid, current_grant, route_sel, direction,
               busy, beat_count, pkt_done, timeout_err, drop_err
    );

    modport slave (
        input  arb_enable, req_valid, req_last, req_dest_addr, out_ready,
        output req_pop, grant_valid, current_grant, route_sel, direction,
               busy, beat_count, pkt_done, timeout_err, drop_err
    );
endinterface

// File: rtl/leaf_xbar_scheduler_rr_pick5.sv
// Combinational round-robin picker over five requesters: the first set bit
// strictly after the pointer wins, wrapping from index 4 back to 0.
module rr_pick5
    import leaf_noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] pointer,
    output logic       any,
    output logic [2:0] idx
);

    int cand;

    always_comb begin
        any  = |req;
        idx  = PORT_GPU;
        cand = 0;
        // Walk from the farthest offset inward so the nearest requester is assigned last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(pointer) + k) % NUM_REQ;
            if (req[cand]) idx = 3'(cand);
        end
    end

endmodule

// File: rtl/leaf_xbar_scheduler.sv
// Single-path crossbar scheduler for the leaf router: grants one requester at a
// time, decodes its route at grant, and holds it until last beat or stall timeout.
module leaf_xbar_scheduler
    import leaf_noc_pkg::*;
#(
    parameter int         DWIDTH         = 16,
    parameter logic [3:0] GROUP_ID       = 4'b0001,
    parameter int         ROUTER_ID      = 4,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         CNT_W          = 8
) (
    input logic                  clk,
    input logic                  reset,
    leaf_xbar_scheduler_if.slave bus
);

    localparam int         STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] SELF_RT = 2'(ROUTER_ID);

    if (DWIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("leaf_xbar_scheduler: need DWIDTH >= 1 and TIMEOUT_CYCLES >= 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_e             state;
    logic [2:0]         rr_ptr;
    logic [STALL_W-1:0] stall_cnt;
    logic               grant_valid;
    logic [2:0]         current_grant;
    logic [2:0]         route_sel;
    dir_e               direction;
    logic               busy;
    logic [CNT_W-1:0]   beat_count;
    logic               pkt_done;
    logic               timeout_err;
    logic               drop_err;

    logic       gnt_any;
    logic [2:0] gnt_idx;
    logic [5:0] win_dest;
    logic       win_self;
    dir_e       dec_dir;
    logic [2:0] dec_route;
    logic       pop_ok;

    rr_pick5 u_pick (
        .req     (bus.req_valid),
        .pointer (rr_ptr),
        .any     (gnt_any),
        .idx     (gnt_idx)
    );

    // Route of the would-be winner; only captured on the granting edge.
    always_comb begin
        win_dest  = bus.req_dest_addr[gnt_idx*6 +: 6];
        win_self  = (addr_group(win_dest) == GROUP_ID) && (addr_router(win_dest) == SELF_RT);
        dec_dir   = DIR_DROP;
        dec_route = PORT_GPU;
        if (gnt_idx == PORT_GPU) begin
            if (!win_self) begin
                dec_dir   = DIR_UP;
                dec_route = PORT_SP1 + {1'b0, addr_router(win_dest)};
            end
        end else if (win_self) begin
            dec_dir = DIR_DOWN;
        end
    end

    // Drop-routed packets ignore downstream ready so they drain at line rate.
    always_comb begin
        pop_ok = 1'b0;
        if (state == ST_XFER && bus.req_valid[current_grant])
            pop_ok = (direction == DIR_DROP) || bus.out_ready[route_sel];
        bus.req_pop = {4'b0000, pop_ok} << current_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= PORT_SP4;
            stall_cnt     <= '0;
            grant_valid   <= 1'b0;
            current_grant <= PORT_GPU;
            route_sel     <= PORT_GPU;
            direction     <= DIR_IDLE;
            busy          <= 1'b0;
            beat_count    <= '0;
            pkt_done      <= 1'b0;
            timeout_err   <= 1'b0;
            drop_err      <= 1'b0;
        end else begin
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
            drop_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.arb_enable && gnt_any) begin
                        state         <= ST_XFER;
                        busy          <= 1'b1;
                        grant_valid   <= 1'b1;
                        current_grant <= gnt_idx;
                        route_sel     <= dec_route;
                        direction     <= dec_dir;
                        beat_count    <= '0;
                        stall_cnt     <= '0;
                    end
                end
                ST_XFER: begin
                    if (pop_ok) begin
                        beat_count <= sat_inc(beat_count);
                        stall_cnt  <= '0;
                        if (bus.req_last[current_grant]) begin
                            pkt_done    <= 1'b1;
                            drop_err    <= (direction == DIR_DROP);
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            grant_valid <= 1'b0;
                            direction   <= DIR_IDLE;
                            rr_ptr      <= current_grant;
                        end
                    end else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        grant_valid <= 1'b0;
                        direction   <= DIR_IDLE;
                        rr_ptr      <= current_grant;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant_valid   = grant_valid;
    assign bus.current_grant = current_grant;
    assign bus.route_sel     = route_sel;
    assign bus.direction     = direction;
    assign bus.busy          = busy;
    assign bus.beat_count    = beat_count;
    assign bus.pkt_done      = pkt_done;
    assign bus.timeout_err   = timeout_err;
    assign bus.drop_err      = drop_err;

endmodule

// File: tb/tb_leaf_xbar_scheduler.sv
// Bench for leaf_xbar_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a packet-level model of the scheduling rules.
module tb_leaf_xbar_scheduler;

    localparam int CNT_W = 8;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_xbar_scheduler_if #(.CNT_W(CNT_W)) bus ();

    leaf_xbar_scheduler #(
        .DWIDTH(16), .GROUP_ID(4'b0001), .ROUTER_ID(4),
        .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Packet-level model: who holds the crossbar, where it goes, progress so far.
    bit         started = 0;
    bit         m_busy;
    int         m_g, m_route, m_dir, m_cnt, m_stall, m_ptr;
    bit         m_pd, m_to, m_de;
    logic [4:0] e_pop, last_pop;
    int         pick;
    logic [5:0] pdest;

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_route = 0; m_dir = 0; m_cnt = 0; m_stall = 0;
        m_ptr = 4; m_pd = 0; m_to = 0; m_de = 0;
    endtask

    task automatic model_release();
        m_busy = 0; m_dir = 0; m_ptr = m_g;
    endtask

    initial forever begin
        @(negedge clk);
        e_pop = '0;
        if (m_busy && bus.req_valid[m_g] && (m_dir == 3 || bus.out_ready[m_route]))
            e_pop[m_g] = 1'b1;
        if (started) begin
            chk("req_pop",       bus.req_pop,       e_pop);
            chk("grant_valid",   bus.grant_valid,   m_busy);
            chk("busy",          bus.busy,          m_busy);
            chk("current_grant", bus.current_grant, m_g);
            chk("route_sel",     bus.route_sel,     m_route);
            chk("direction",     bus.direction,     m_dir);
            chk("beat_count",    bus.beat_count,    m_cnt);
            chk("pkt_done",      bus.pkt_done,      m_pd);
            chk("timeout_err",   bus.timeout_err,   m_to);
            chk("drop_err",      bus.drop_err,      m_de);
        end
        last_pop = bus.req_pop;
        if (reset) begin
            model_reset();
            started = 1;
        end else if (started) begin
            m_pd = 0; m_to = 0; m_de = 0;
            if (!m_busy) begin
                if (bus.arb_enable && bus.req_valid != 0) begin
                    pick = -1;
                    for (int k = 1; k <= 5; k++)
                        if (pick < 0 && bus.req_valid[(m_ptr + k) % 5]) pick = (m_ptr + k) % 5;
                    pdest = bus.req_dest_addr[pick*6 +: 6];
                    m_g = pick; m_busy = 1; m_cnt = 0; m_stall = 0; m_route = 0;
                    if ((pdest / 4 == 1) && (pdest % 4 == 0)) m_dir = (pick == 0) ? 3 : 1;
                    else if (pick == 0) begin m_dir = 2; m_route = pdest % 4 + 1; end
                    else m_dir = 3;
                end
            end else if (e_pop != 0) begin
                if (m_cnt < 255) m_cnt++;
                m_stall = 0;
                if (bus.req_last[m_g]) begin
                    m_pd = 1; m_de = (m_dir == 3);
                    model_release();
                end
            end else begin
                m_stall++;
                if (m_stall == TO) begin m_to = 1; model_release(); end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_dest(input int i, input logic [5:0] d);
        bus.req_dest_addr[i*6 +: 6] = d;
    endtask

    // Random traffic sources: one packet in progress per requester.
    int         rem [5];
    int         sil [5];
    logic [5:0] pdst [5];

    task automatic new_pkt(input int i);
        rem[i] = $urandom_range(1, 4);
        if ($urandom_range(0, 1) == 0) pdst[i] = 6'b0001_00;
        else pdst[i] = 6'($urandom_range(0, 63));
    endtask

    initial begin
        reset = 1'b1;
        bus.arb_enable = 1'b1; bus.req_valid = '0; bus.req_last = '0;
        bus.req_dest_addr = '0; bus.out_ready = '0;
        cyc(2);
        chk("rst_grant_valid", bus.grant_valid, 0);
        chk("rst_direction",   bus.direction,   0);
        reset = 1'b0;
        bus.out_ready = 5'b11111;

        // Spine2 to the local GPU, three beats.
        set_dest(2, 6'b0001_00); bus.req_valid = 5'b00100;
        cyc();
        chk("t1_grant", bus.current_grant, 2);
        chk("t1_dir",   bus.direction,     1);
        chk("t1_route", bus.route_sel,     0);
        chk("t1_pop",   bus.req_pop,       5'b00100);
        chk("t1_model_dir", m_dir, 1);
        cyc(2);
        bus.req_last = 5'b00100;
        cyc();
        bus.req_valid = '0; bus.req_last = '0;
        chk("t1_done", bus.pkt_done,   1);
        chk("t1_cnt",  bus.beat_count, 3);

        // GPU up to spine3 with that port stalled for four cycles.
        set_dest(0, 6'b0010_10); bus.req_valid = 5'b00001; bus.out_ready = 5'b10111;
        cyc();
        chk("t2_dir",   bus.direction, 2);
        chk("t2_route", bus.route_sel, 3);
        chk("t2_stall_pop", bus.req_pop, 0);
        cyc(3);
        bus.out_ready = 5'b11111; #1;
        chk("t2_resume_pop", bus.req_pop, 5'b00001);
        cyc();
        bus.req_last = 5'b00001;
        cyc();
        bus.req_valid = '0; bus.req_last = '0;
        chk("t2_done", bus.pkt_done,    1);
        chk("t2_noto", bus.timeout_err, 0);
        chk("t2_cnt",  bus.beat_count,  2);

        // Spine1 misrouted: dropped even with every output blocked.
        set_dest(1, 6'b0011_01); bus.req_valid = 5'b00010; bus.out_ready = '0;
        cyc();
        chk("t3_dir", bus.direction, 3);
        chk("t3_pop", bus.req_pop,   5'b00010);
        cyc();
        bus.req_last = 5'b00010;
        cyc();
        bus.req_valid = '0; bus.req_last = '0;
        chk("t3_drop", bus.drop_err, 1);
        chk("t3_done", bus.pkt_done, 1);

        // Everyone requesting single-beat packets from reset.
        reset = 1'b1; cyc(); reset = 1'b0;
        bus.out_ready = 5'b11111; bus.req_valid = 5'b11111; bus.req_last = 5'b11111;
        set_dest(0, 6'b0000_00);
        for (int i = 1; i < 5; i++) set_dest(i, 6'b0001_00);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t4_grant", bus.current_grant, k % 5);
            chk("t4_busy",  bus.busy, 1);
            cyc();
            chk("t4_bubble", bus.busy, 0);
        end
        bus.req_valid = '0; bus.req_last = '0;

        // GPU goes silent after the grant until the stall limit.
        set_dest(0, 6'b0010_10); bus.req_valid = 5'b00001;
        cyc();
        bus.req_valid = '0;
        cyc(TO - 1);
        chk("t5_early_to", bus.timeout_err, 0);
        cyc();
        chk("t5_to",   bus.timeout_err, 1);
        chk("t5_idle", bus.busy,        0);
        set_dest(1, 6'b0001_00); bus.req_valid = 5'b00011; bus.req_last = 5'b00010;
        cyc();
        chk("t5_next_grant", bus.current_grant, 1);
        chk("t5_next_dir",   bus.direction,     1);
        cyc();
        bus.req_valid = '0; bus.req_last = '0;

        // Reset in the middle of a packet, then arbitration held off.
        bus.req_valid = 5'b00001;
        cyc(2);
        reset = 1'b1;
        cyc();
        reset = 1'b0; bus.arb_enable = 1'b0; bus.req_valid = 5'b00110;
        chk("t6_gv",    bus.grant_valid,   0);
        chk("t6_cnt",   bus.beat_count,    0);
        chk("t6_grant", bus.current_grant, 0);
        cyc(3);
        chk("t6_held", bus.grant_valid, 0);
        bus.arb_enable = 1'b1;
        cyc();
        chk("t6_first", bus.current_grant, 1);
        bus.req_last = 5'b00110;
        cyc();
        bus.req_valid = '0; bus.req_last = '0;
        cyc();

        // Random traffic.
        for (int i = 0; i < 5; i++) begin new_pkt(i); sil[i] = 0; end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (last_pop[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) new_pkt(i);
                end
                if (sil[i] > 0) begin
                    sil[i]--; bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    sil[i] = $urandom_range(14, 24); bus.req_valid[i] = 1'b0;
                end else begin
                    bus.req_valid[i] = ($urandom_range(0, 9) < 8);
                end
                bus.req_last[i] = (rem[i] == 1);
                if ($urandom_range(0, 19) == 0) set_dest(i, 6'($urandom_range(0, 63)));
                else set_dest(i, pdst[i]);
                bus.out_ready[i] = ($urandom_range(0, 9) < 7);
            end
            bus.arb_enable = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 699) == 0);
            cyc();
        end
        reset = 1'b0; bus.req_valid = '0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
